debug_cmd_loader: RTL and testbench

//  Command front-end of the UART debug unit. Decodes bytes from the UART receiver and

---
 rtl/debug_cmd_loader.sv | 216 +++++++++++++++++++++
 tb/tb_debug_cmd_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_loader.sv
// UART debug command front-end: decodes LOAD/STEP/RUN opcodes, assembles LOAD
// payload bytes into instruction words, writes them to instruction memory and
// answers each load with a one-byte ACK carrying the number of words written.
module debug_cmd_loader #(
   parameter int                      WORD_BYTES  = 4,
   parameter int                      ADDR_W      = 8,
   parameter int                      BIG_ENDIAN  = 1,
   parameter int                      TIMEOUT_CYC = 100000,
   parameter logic [7:0]              CMD_LOAD    = 8'h01,
   parameter logic [7:0]              CMD_STEP    = 8'h02,
   parameter logic [7:0]              CMD_RUN     = 8'h03,
   parameter logic [8*WORD_BYTES-1:0] HALT_WORD   = '1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_done_tick,
   output logic [7:0]                tx_data,
   output logic                      tx_start,
   input  logic                      tx_done_tick,
   output logic                      imem_we,
   output logic [ADDR_W-1:0]         imem_addr,
   output logic [8*WORD_BYTES-1:0]   imem_wdata,
   output logic                      step_pulse,
   output logic                      run_pulse,
   output logic                      loading,
   output logic                      err_timeout,
   output logic                      err_cmd,
   output logic                      mem_full,
   output logic [2:0]                state_o
);

   localparam int W     = 8 * WORD_BYTES;
   localparam int BC_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int WC_W  = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
      S_ACK     = 3'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [W-1:0]      buf_q, buf_d;
   logic              started_q, started_d;
   logic              step_q, step_d;
   logic              run_q, run_d;
   logic              err_timeout_q, err_timeout_d;
   logic              err_cmd_q, err_cmd_d;
   logic              mem_full_q, mem_full_d;

   // Place one byte into the word at the lane selected by its index and endianness.
   function automatic logic [W-1:0] put_byte(input logic [W-1:0]    word,
                                             input logic [BC_W-1:0] idx,
                                             input logic [7:0]      b);
      logic [W-1:0] r;
      int           pos;
      r   = word;
      pos = (BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - int'(idx)) : int'(idx);
      r[8*pos +: 8] = b;
      return r;
   endfunction

   // Next-state and datapath update for the command/load FSM.
   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
      state_d       = state_q;
      addr_d        = addr_q;
      byte_cnt_d    = byte_cnt_q;
      word_cnt_d    = word_cnt_q;
      timer_d       = timer_q;
      buf_d         = buf_q;
      started_d     = started_q;
      step_d        = 1'b0;
      run_d         = 1'b0;
      err_timeout_d = err_timeout_q;
      err_cmd_d     = err_cmd_q;
      mem_full_d    = mem_full_q;

      case (state_q)
         S_IDLE: begin
            if (rx_done_tick) begin
               if (rx_data == CMD_LOAD) begin
                  state_d       = S_COLLECT;
                  addr_d        = '0;
                  byte_cnt_d    = '0;
                  word_cnt_d    = '0;
                  timer_d       = '0;
                  started_d     = 1'b0;
                  err_timeout_d = 1'b0;
                  err_cmd_d     = 1'b0;
                  mem_full_d    = 1'b0;
               end else if (rx_data == CMD_STEP) begin
                  step_d = 1'b1;
               end else if (rx_data == CMD_RUN) begin
                  run_d = 1'b1;
               end else begin
                  err_cmd_d = 1'b1;
               end
            end
         end

         S_COLLECT: begin
            if (rx_done_tick) begin
               buf_d     = put_byte(buf_q, byte_cnt_q, rx_data);
               timer_d   = '0;
               started_d = 1'b1;
               if (byte_cnt_q == BC_LAST) begin
                  byte_cnt_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
               end
            end else if (TIMEOUT_CYC != 0 && started_q) begin
               // The silence clock only starts once the frame has delivered a payload byte.
               if (timer_q == TMR_LAST) begin
                  err_timeout_d = 1'b1;
                  state_d       = S_ACK;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end

         S_WRITE: begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            if (buf_q == HALT_WORD) begin
               state_d = S_ACK;
            end else if (addr_q == ADDR_LAST) begin
               mem_full_d = 1'b1;
               state_d    = S_ACK;
            end else begin
               addr_d     = addr_q + ADDR_W'(1);
               byte_cnt_d = '0;
               timer_d    = '0;
               state_d    = S_COLLECT;
               // A byte arriving during the write cycle is byte 0 of the next word.
               if (rx_done_tick) begin
                  buf_d = put_byte(buf_q, '0, rx_data);
                  if (BC_LAST == '0) begin
                     state_d = S_WRITE;
                  end else begin
                     byte_cnt_d = BC_W'(1);
                  end
               end
            end
         end

         S_ACK: begin
            // Bytes received while acknowledging are dropped, even alongside tx_done_tick.
            if (tx_done_tick) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         byte_cnt_q    <= '0;
         word_cnt_q    <= '0;
         timer_q       <= '0;
         // NOTE: the word buffer drives imem_wdata directly, so it is reset to keep outputs at 0.
         buf_q         <= '0;
         started_q     <= 1'b0;
         step_q        <= 1'b0;
         run_q         <= 1'b0;
         err_timeout_q <= 1'b0;
         err_cmd_q     <= 1'b0;
         mem_full_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q       <= state_d;
         addr_q        <= addr_d;
         byte_cnt_q    <= byte_cnt_d;
         word_cnt_q    <= word_cnt_d;
         timer_q       <= timer_d;
         buf_q         <= buf_d;
         started_q     <= started_d;
         step_q        <= step_d;
         run_q         <= run_d;
         err_timeout_q <= err_timeout_d;
         err_cmd_q     <= err_cmd_d;
         mem_full_q    <= mem_full_d;
      end
   end

   assign imem_we     = (state_q == S_WRITE);
   assign imem_addr   = addr_q;
   assign imem_wdata  = buf_q;
   assign tx_start    = (state_q == S_ACK);
   assign tx_data     = tx_start ? word_cnt_q[7:0] : 8'h00;
   assign loading     = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign step_pulse  = step_q;
   assign run_pulse   = run_q;
   assign err_timeout = err_timeout_q;
   assign err_cmd     = err_cmd_q;
   assign mem_full    = mem_full_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_debug_cmd_loader.sv
// Bench for debug_cmd_loader. Instance A (big-endian, 4-address memory, 50-cycle
// timeout) is checked every cycle against a transaction-level model; instance B
// (little-endian, timeout disabled) is checked with hand-computed expectations.
module tb_debug_cmd_loader;

   logic clk;
   logic reset;

   // Instance A
   logic [7:0]  a_rx;
   logic        a_tick, a_done;
   logic [7:0]  a_txd;
   logic        a_txs, a_we, a_step, a_run, a_load, a_to, a_cmd, a_full;
   logic [1:0]  a_addr;
   logic [31:0] a_wdata;
   logic [2:0]  a_state;

   // Instance B
   logic [7:0]  b_rx;
   logic        b_tick, b_done;
   logic [7:0]  b_txd;
   logic        b_txs, b_we, b_step, b_run, b_load, b_to, b_cmd, b_full;
   logic [7:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_state;

   debug_cmd_loader #(.WORD_BYTES(4), .ADDR_W(2), .BIG_ENDIAN(1), .TIMEOUT_CYC(50)) u_a (
      .clk(clk), .reset(reset), .rx_data(a_rx), .rx_done_tick(a_tick),
      .tx_data(a_txd), .tx_start(a_txs), .tx_done_tick(a_done),
      .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
      .step_pulse(a_step), .run_pulse(a_run), .loading(a_load),
      .err_timeout(a_to), .err_cmd(a_cmd), .mem_full(a_full), .state_o(a_state)
   );

   debug_cmd_loader #(.WORD_BYTES(4), .ADDR_W(8), .BIG_ENDIAN(0), .TIMEOUT_CYC(0)) u_b (
      .clk(clk), .reset(reset), .rx_data(b_rx), .rx_done_tick(b_tick),
      .tx_data(b_txd), .tx_start(b_txs), .tx_done_tick(b_done),
      .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
      .step_pulse(b_step), .run_pulse(b_run), .loading(b_load),
      .err_timeout(b_to), .err_cmd(b_cmd), .mem_full(b_full), .state_o(b_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of instance A ----------------
   localparam int          M_WB   = 4;
   localparam int          M_AW   = 2;
   localparam int          M_TO   = 50;
   localparam logic [31:0] M_HALT = 32'hFFFF_FFFF;

   int          m_state, m_addr, m_wc, m_nb, m_silent;
   bit          m_started, m_to, m_cmd, m_full, m_step, m_run;
   logic [31:0] m_word;

   task take_byte(input logic [7:0] b);
      m_word    = (m_word << 8) | {24'h0, b};
      m_nb      = m_nb + 1;
      m_started = 1'b1;
      m_silent  = 0;
      if (m_nb == M_WB) m_state = 2;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state = 0; m_addr = 0; m_wc = 0; m_nb = 0; m_silent = 0;
         m_started = 0; m_to = 0; m_cmd = 0; m_full = 0; m_step = 0; m_run = 0;
         m_word = '0;
      end else begin
         m_step = 0;
         m_run  = 0;
         case (m_state)
            0: if (a_tick) begin
                  if (a_rx == 8'h01) begin
                     m_to = 0; m_cmd = 0; m_full = 0;
                     m_addr = 0; m_wc = 0; m_nb = 0; m_word = '0;
                     m_started = 0; m_silent = 0; m_state = 1;
                  end else if (a_rx == 8'h02) m_step = 1;
                  else if (a_rx == 8'h03) m_run = 1;
                  else m_cmd = 1;
               end
            1: if (a_tick) take_byte(a_rx);
               else if (m_started) begin
                  m_silent = m_silent + 1;
                  if (m_silent == M_TO) begin
                     m_to    = 1;
                     m_state = 3;
                  end
               end
            2: begin
                  m_wc = m_wc + 1;
                  if (m_word == M_HALT) m_state = 3;
                  else if (m_addr == (1 << M_AW) - 1) begin
                     m_full  = 1;
                     m_state = 3;
                  end else begin
                     m_addr = m_addr + 1; m_nb = 0; m_word = '0; m_silent = 0;
                     m_state = 1;
                     if (a_tick) take_byte(a_rx);
                  end
               end
            3: if (a_done) m_state = 0;
            default: m_state = 0;
         endcase
      end
   end

   // Per-cycle comparison of instance A against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("state_o",     a_state, m_state);
         check("imem_we",     a_we,    m_state == 2);
         check("imem_addr",   a_addr,  m_addr);
         if (m_state == 2) check("imem_wdata", a_wdata, m_word);
         check("tx_start",    a_txs,   m_state == 3);
         check("tx_data",     a_txd,   (m_state == 3) ? (m_wc & 255) : 0);
         check("step_pulse",  a_step,  m_step);
         check("run_pulse",   a_run,   m_run);
         check("loading",     a_load,  m_state == 1 || m_state == 2);
         check("err_timeout", a_to,    m_to);
         check("err_cmd",     a_cmd,   m_cmd);
         check("mem_full",    a_full,  m_full);
      end
   end

   // Write and pulse capture for literal expectations.
   logic [39:0] qa[$];
   logic [39:0] qb[$];
   int          step_cnt, run_cnt;

   always @(negedge clk) begin
      if (a_we === 1'b1) qa.push_back({6'h0, a_addr, a_wdata});
      if (b_we === 1'b1) qb.push_back({b_addr, b_wdata});
      if (a_step === 1'b1) step_cnt++;
      if (a_run === 1'b1) run_cnt++;
   end

   // ---------------- stimulus helpers (entered at a falling edge) ----------------
   task automatic send(input bit sel, input logic [7:0] b, input int gap);
      if (!sel) begin a_rx = b; a_tick = 1'b1; end
      else      begin b_rx = b; b_tick = 1'b1; end
      @(negedge clk);
      a_tick = 1'b0;
      b_tick = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] bytes[$], input int gap);
      foreach (bytes[i]) send(sel, bytes[i], gap);
   endtask

   task automatic wait_ack(input bit sel, output logic [7:0] txd);
      int n = 0;
      while (((sel ? b_state : a_state) != 3'd3) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("ack_reached", sel ? b_state : a_state, 3);
      txd = sel ? b_txd : a_txd;
      repeat (2) @(negedge clk);
      if (!sel) a_done = 1'b1; else b_done = 1'b1;
      @(negedge clk);
      a_done = 1'b0;
      b_done = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] fr[$];
      logic [7:0] txd;

      reset = 1'b0;
      a_rx = '0; a_tick = 0; a_done = 0;
      b_rx = '0; b_tick = 0; b_done = 0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      cmp_en = 1'b1;
      check("rst_state", a_state, 0);
      check("rst_tx", {a_txs, a_txd}, 0);
      @(negedge clk);

      // T1: big-endian load ending with HALT_WORD, bytes back-to-back
      qa.delete();
      fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_frame(0, fr, 0);
      wait_ack(0, txd);
      check("t1_ack", txd, 8'h02);
      check("t1_nwr", qa.size(), 2);
      if (qa.size() >= 2) begin
         check("t1_w0", qa[0], 40'h00_000000FC);
         check("t1_w1", qa[1], 40'h01_FFFFFFFF);
      end

      // T2: little-endian instance
      qb.delete();
      fr = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_frame(1, fr, 1);
      wait_ack(1, txd);
      check("t2_ack", txd, 8'h02);
      check("t2_nwr", qb.size(), 2);
      if (qb.size() >= 2) begin
         check("t2_w0", qb[0], 40'h00_00000004);
         check("t2_w1", qb[1], 40'h01_FFFFFFFF);
      end
      // Timeout disabled: a stalled frame stays loading indefinitely.
      fr = '{8'h01, 8'hAA};
      send_frame(1, fr, 0);
      repeat (200) @(negedge clk);
      check("t2_noto_state", b_state, 3'd1);
      check("t2_noto_flag", b_to, 1'b0);

      // T3: payload timeout 50 cycles after the last byte
      qa.delete();
      fr = '{8'h01, 8'hAA, 8'hBB};
      send_frame(0, fr, 0);
      repeat (49) @(negedge clk);
      check("t3_to_49", a_to, 1'b0);
      @(negedge clk);
      check("t3_to_50", a_to, 1'b1);
      wait_ack(0, txd);
      check("t3_ack", txd, 8'h00);
      check("t3_nwr", qa.size(), 0);

      // T4: memory full at the last address without HALT_WORD
      qa.delete();
      fr = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
      send_frame(0, fr, 1);
      wait_ack(0, txd);
      check("t4_ack", txd, 8'h04);
      check("t4_full", a_full, 1'b1);
      check("t4_nwr", qa.size(), 4);
      if (qa.size() >= 4) begin
         check("t4_w0", qa[0], 40'h00_11223344);
         check("t4_w3", qa[3], 40'h03_0A0B0C0D);
      end

      // T5: step, run, unknown opcode
      step_cnt = 0;
      run_cnt  = 0;
      send(0, 8'h02, 3);
      send(0, 8'h03, 3);
      send(0, 8'h7E, 3);
      check("t5_steps", step_cnt, 1);
      check("t5_runs", run_cnt, 1);
      check("t5_errcmd", a_cmd, 1'b1);
      check("t5_full_sticky", a_full, 1'b1);

      // T6: reset in the middle of a load, then a fresh load from address 0
      fr = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      send_frame(0, fr, 1);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_rst_state", a_state, 3'd0);
      check("t6_rst_outs", {a_we, a_txs, a_step, a_run, a_load, a_to, a_cmd, a_full}, 8'h00);
      check("t6_rst_addr", a_addr, 2'd0);
      #2 reset = 1'b1;
      @(negedge clk);
      qa.delete();
      step_cnt = 0;
      fr = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_frame(0, fr, 0);
      begin
         int n = 0;
         while (a_state != 3'd3 && n < 300) begin
            @(negedge clk);
            n++;
         end
         if (n >= 300) check("t6_ack_reached", a_state, 3);
      end
      check("t6_ack", a_txd, 8'h02);
      // ACK completes on tx_done_tick; a simultaneous STEP byte is dropped.
      a_rx = 8'h02; a_tick = 1'b1; a_done = 1'b1;
      @(negedge clk);
      a_tick = 1'b0; a_done = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_nwr", qa.size(), 2);
      if (qa.size() >= 1) check("t6_w0", qa[0], 40'h00_DEADBEEF);
      check("t6_drop_step", step_cnt, 0);
      check("t6_idle", a_state, 3'd0);

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
